// File: rtl/seg7_scan_mux_pkg.sv
// seg7_pkg: shared types, segment constants and BCD decode for the
// seg7_scan_mux display slice.
//   seg7_t       7-bit segment vector {a,b,c,d,e,f,g}, active-high
//   SEG_BLANK    all segments off
//   SEG_DASH     centre bar only (shown for non-BCD codes 10..15)
//   bcd_to_seg7  BCD digit -> segment pattern
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'b0000000;
    localparam seg7_t SEG_DASH  = 7'b0000001;

    function automatic seg7_t bcd_to_seg7(input logic [3:0] bcd);
        seg7_t s;
        case (bcd)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1110011;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_scan_mux_if.sv
// seg7_scan_mux_if: load/data inputs and multiplexed display outputs of
// seg7_scan_mux.
//   load        1-cycle strobe capturing digits_bcd/dp_in
//   digits_bcd  packed BCD, digit i at [4*i+3:4*i]
//   dp_in       decimal point per digit
//   seg         segment bus of the lit digit
//   dp          decimal point of the lit digit
//   dig_en      one-hot digit enable
//   frame_start 1-cycle pulse at the start of a frame
// Modports: master = producer / display side, slave = seg7_scan_mux.
interface seg7_scan_mux_if #(
    parameter int N_DIG = 2
);
    import seg7_pkg::*;

    logic               load;
    logic [4*N_DIG-1:0] digits_bcd;
    logic [N_DIG-1:0]   dp_in;
    seg7_t              seg;
    logic               dp;
    logic [N_DIG-1:0]   dig_en;
    logic               frame_start;

    modport master (
        output load, digits_bcd, dp_in,
        input  seg, dp, dig_en, frame_start
    );

    modport slave (
        input  load, digits_bcd, dp_in,
        output seg, dp, dig_en, frame_start
    );

endinterface

// File: rtl/seg7_scan_mux_timer.sv
// seg7_scan_timer: slot prescaler and digit scan index.
//   CLK, RST_N  clock, asynchronous active-low reset
//   slot_dead   current cycle lies in the blanking dead-time of the slot
//   idx         digit currently being scanned (0 = units)
//   frame_end   last cycle of the last digit slot (frame boundary edge next)
module seg7_scan_timer #(
    parameter int REFRESH_DIV = 1000,
    parameter int DEAD_CYC    = 4,
    parameter int N_DIG       = 2,
    parameter int IDX_W       = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    output logic             slot_dead,
    output logic [IDX_W-1:0] idx,
    output logic             frame_end
);

    localparam int CNT_W = $clog2(REFRESH_DIV);

    logic [CNT_W-1:0] cnt;
    logic             slot_end;
    logic             last_dig;

    assign slot_end  = (cnt == CNT_W'(REFRESH_DIV - 1));
    assign last_dig  = (idx == IDX_W'(N_DIG - 1));
    assign slot_dead = (cnt < CNT_W'(DEAD_CYC));
    assign frame_end = slot_end && last_dig;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= last_dig ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexes N_DIG BCD digits onto one 7-segment bus.
// New values are loaded frame-synchronously so a frame never mixes
// snapshots. Each digit slot opens with DEAD_CYC cycles of blanking.
//   CLK, RST_N  clock, asynchronous active-low reset
//   bus         seg7_scan_mux_if.slave (load/data in, seg/dp/dig_en/frame_start out)
// Optional build macro: LEADING_ZERO_BLANK_EN -- blank leading zero digits
// (digit 0 is always shown; dig_en and dp are unaffected).
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int N_DIG       = 2,
    parameter int REFRESH_DIV = 1000,
    parameter int DEAD_CYC    = 4
) (
    input  logic CLK,
    input  logic RST_N,
    seg7_scan_mux_if.slave bus
);

    localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;

    logic             slot_dead;
    logic [IDX_W-1:0] idx;
    logic             frame_end;

    seg7_scan_timer #(
        .REFRESH_DIV (REFRESH_DIV),
        .DEAD_CYC    (DEAD_CYC),
        .N_DIG       (N_DIG),
        .IDX_W       (IDX_W)
    ) u_timer (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .slot_dead (slot_dead),
        .idx       (idx),
        .frame_end (frame_end)
    );

    // Snapshot registers: active is what the current frame shows, pending
    // holds the latest mid-frame load until the next boundary.
    logic [4*N_DIG-1:0] active, pending;
    logic [N_DIG-1:0]   active_dp, pending_dp;
    logic               pend;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            active     <= '0;
            active_dp  <= '0;
            pending    <= '0;
            pending_dp <= '0;
            pend       <= 1'b0;
        end else if (frame_end) begin
            // A load on the boundary edge bypasses pending and takes effect
            // in the frame that starts now; any older pending value is dropped.
            if (bus.load) begin
                active    <= bus.digits_bcd;
                active_dp <= bus.dp_in;
            end else if (pend) begin
                active    <= pending;
                active_dp <= pending_dp;
            end
            pend <= 1'b0;
        end else if (bus.load) begin
            pending    <= bus.digits_bcd;
            pending_dp <= bus.dp_in;
            pend       <= 1'b1;
        end
    end

    logic [3:0] act_dig [N_DIG];
    logic       blank;
    seg7_t      seg_nxt;

    always_comb begin
        for (int unsigned i = 0; i < N_DIG; i++) begin
            act_dig[i] = active[4*i +: 4];
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // zero_from[i]: digit i and every more significant digit are zero.
    logic [N_DIG-1:0] zero_from;

    always_comb begin
        zero_from = '1;
        for (int unsigned i = 0; i < N_DIG; i++) begin
            for (int unsigned j = 0; j < N_DIG; j++) begin
                if (j >= i && act_dig[j] != 4'd0) begin
                    zero_from[i] = 1'b0;
                end
            end
        end
    end

    assign blank = (idx != '0) && zero_from[idx];
`else
    assign blank = 1'b0;
`endif

    assign seg_nxt = blank ? SEG_BLANK : bcd_to_seg7(act_dig[idx]);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bus.seg         <= SEG_BLANK;
            bus.dp          <= 1'b0;
            bus.dig_en      <= '0;
            bus.frame_start <= 1'b0;
        end else begin
            bus.frame_start <= frame_end;
            if (slot_dead) begin
                bus.seg    <= SEG_BLANK;
                bus.dp     <= 1'b0;
                bus.dig_en <= '0;
            end else begin
                bus.seg    <= seg_nxt;
                bus.dp     <= active_dp[idx];
                bus.dig_en <= N_DIG'(1) << idx;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux: directed test of seg7_scan_mux with N_DIG=2,
// REFRESH_DIV=8, DEAD_CYC=2. Edge k (1-based, counted from reset release)
// processes cnt=(k-1)%8, idx=((k-1)/8)%2; frame boundaries are k=16,32,...
module tb_seg7_scan_mux;
    import seg7_pkg::*;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;

    seg7_scan_mux_if #(.N_DIG(2)) bus ();

    seg7_scan_mux #(
        .N_DIG       (2),
        .REFRESH_DIV (8),
        .DEAD_CYC    (2)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    localparam seg7_t S0 = 7'b1111110;
    localparam seg7_t S1 = 7'b0110000;
    localparam seg7_t S2 = 7'b1101101;
    localparam seg7_t S5 = 7'b1011011;
    localparam seg7_t S6 = 7'b1011111;
    localparam seg7_t S7 = 7'b1110000;
    localparam seg7_t S9 = 7'b1110011;
`ifdef LEADING_ZERO_BLANK_EN
    localparam seg7_t Z0 = 7'b0000000;   // leading zero in tens slot
`else
    localparam seg7_t Z0 = 7'b1111110;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int k = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, k, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        k++;
    endtask

    task automatic run_to(input int target);
        while (k < target) tick();
    endtask

    // Present load so that edge number 'e' captures it.
    task automatic do_load(input int e, input logic [7:0] d, input logic [1:0] p);
        run_to(e - 1);
        bus.load       = 1'b1;
        bus.digits_bcd = d;
        bus.dp_in      = p;
        tick();
        bus.load       = 1'b0;
    endtask

    task automatic chk_out(input string tag, input seg7_t s, input logic [1:0] en);
        chk({tag, ".seg"}, 32'(bus.seg), 32'(s));
        chk({tag, ".en"},  32'(bus.dig_en), 32'(en));
    endtask

    initial begin
        bus.load       = 1'b0;
        bus.digits_bcd = '0;
        bus.dp_in      = '0;

        // 1. reset state and release
        repeat (3) @(posedge CLK);
        #1;
        chk_out("rst", 7'd0, 2'b00);
        chk("rst.fs", 32'(bus.frame_start), 32'd0);
        chk("rst.dp", 32'(bus.dp), 32'd0);
        RST_N = 1'b1;
        run_to(1);  chk_out("dead1", 7'd0, 2'b00);
        run_to(2);  chk_out("dead2", 7'd0, 2'b00);
        run_to(3);  chk_out("f0.u", S0, 2'b01);

        // 2. mid-frame load of 12
        do_load(6, 8'h12, 2'b00);
        run_to(11); chk_out("f0.t", Z0, 2'b10);
        run_to(16); chk("fs16", 32'(bus.frame_start), 32'd1);
        run_to(17); chk("fs17", 32'(bus.frame_start), 32'd0);
        run_to(19); chk_out("f1.u", S2, 2'b01);

        // 3. two loads in one frame: last wins
        do_load(20, 8'h34, 2'b00);
        do_load(24, 8'h56, 2'b00);
        run_to(27); chk_out("f1.t", S1, 2'b10);
        run_to(30); chk_out("f1.t2", S1, 2'b10);
        run_to(31); chk("fs31", 32'(bus.frame_start), 32'd0);
        run_to(32); chk("fs32", 32'(bus.frame_start), 32'd1);
        run_to(35); chk_out("f2.u", S6, 2'b01);

        // 4. pending 99, then 07 on the boundary edge overrides and clears pend
        do_load(40, 8'h99, 2'b00);
        run_to(43); chk_out("f2.t", S5, 2'b10);
        do_load(48, 8'h07, 2'b00);
        run_to(51); chk_out("f3.u", S7, 2'b01);
        run_to(59); chk_out("f3.t", Z0, 2'b10);
        run_to(67); chk_out("f4.u", S7, 2'b01);

        // 5. non-BCD dash, then leading zero with decimal point on tens
        do_load(70, 8'hA9, 2'b00);
        run_to(75); chk_out("f4.t", Z0, 2'b10);
        run_to(83); chk_out("f5.u", S9, 2'b01);
        do_load(85, 8'h05, 2'b10);
        run_to(91); chk_out("f5.t", SEG_DASH, 2'b10);
        run_to(97); chk_out("f6.dead", 7'd0, 2'b00);
        chk("f6.dead.dp", 32'(bus.dp), 32'd0);
        run_to(99); chk_out("f6.u", S5, 2'b01);
        chk("f6.u.dp", 32'(bus.dp), 32'd0);
        run_to(105); chk("f6.tdead.dp", 32'(bus.dp), 32'd0);
        run_to(107); chk_out("f6.t", Z0, 2'b10);
        chk("f6.t.dp", 32'(bus.dp), 32'd1);

        // 6. reset mid-slot with a pending load
        do_load(114, 8'h33, 2'b00);
        run_to(115); chk_out("f7.u", S5, 2'b01);
        RST_N = 1'b0;
        #1;
        chk_out("arst", 7'd0, 2'b00);
        chk("arst.dp", 32'(bus.dp), 32'd0);
        @(posedge CLK);
        #1;
        bus.digits_bcd = '0;
        bus.dp_in      = '0;
        RST_N = 1'b1;
        k = 0;
        run_to(3);  chk_out("r.f0.u", S0, 2'b01);
        run_to(16); chk("r.fs16", 32'(bus.frame_start), 32'd1);
        run_to(19); chk_out("r.f1.u", S0, 2'b01);
        chk("r.f1.dp", 32'(bus.dp), 32'd0);
        run_to(27); chk_out("r.f1.t", Z0, 2'b10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        n_errors++;
        $display("FAIL timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1);
    end

endmodule
